// File: rtl/chip8_ps2_keypad_if.sv
// Keypad-side bus of the CHIP-8 PS/2 keypad: held keys, press events, errors.
// The master drives key state; the slave (machine) owns keys_clear.
interface chip8_ps2_keypad_if;
    logic        keys_clear;
    logic [15:0] keys;
    logic        key_down;
    logic [3:0]  key_code;
    logic        frame_err;

    modport master (
        input  keys_clear,
        output keys,
        output key_down,
        output key_code,
        output frame_err
    );

    modport slave (
        output keys_clear,
        input  keys,
        input  key_down,
        input  key_code,
        input  frame_err
    );
endinterface

// File: rtl/chip8_ps2_keypad.sv
// PS/2 set-2 receiver and decoder mapping 16 QWERTY keys onto the CHIP-8
// hex keypad; produces held-key vector, press strobe and frame errors.
module chip8_ps2_keypad #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic ps2_clk,
    input  logic ps2_dat,
    chip8_ps2_keypad_if.master kp
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        D_IDLE,
        D_BREAK,
        D_EXT,
        D_EXT_BREAK
    } dec_state_e;

    logic [1:0]            clk_sync_q;
    logic [1:0]            dat_sync_q;
    logic [FILTER_LEN-1:0] clk_hist_q;
    logic [FILTER_LEN-1:0] dat_hist_q;
    logic                  flt_clk_q;
    logic                  flt_clk_d;
    logic                  flt_dat_q;
    logic                  flt_dat_d;
    logic                  clk_prev_q;
    logic                  fall;
    logic                  smp;

    rx_state_e             rx_state_q;
    rx_state_e             rx_state_d;
    logic [2:0]            bit_cnt_q;
    logic [2:0]            bit_cnt_d;
    logic [7:0]            shift_q;
    logic [7:0]            shift_d;
    logic [TMO_W-1:0]      tmo_q;
    logic [TMO_W-1:0]      tmo_d;
    logic                  byte_valid_q;
    logic                  byte_valid_d;
    logic                  frame_err_q;
    logic                  frame_err_d;

    dec_state_e            dec_q;
    dec_state_e            dec_d;
    logic [15:0]           keys_q;
    logic [15:0]           keys_d;
    logic                  key_down_q;
    logic                  key_down_d;
    logic [3:0]            key_code_q;
    logic [3:0]            key_code_d;
    logic [4:0]            lut;
    logic                  hit;
    logic [3:0]            hex;

    // Returns {hit, hex} for the 16 keys of the 1234/QWER/ASDF/ZXCV block.
    function automatic logic [4:0] map_code(input logic [7:0] sc);
        logic [4:0] r;
        r = 5'h00;
        case (sc)
            8'h16: r = {1'b1, 4'h1};
            8'h1E: r = {1'b1, 4'h2};
            8'h26: r = {1'b1, 4'h3};
            8'h25: r = {1'b1, 4'hC};
            8'h15: r = {1'b1, 4'h4};
            8'h1D: r = {1'b1, 4'h5};
            8'h24: r = {1'b1, 4'h6};
            8'h2D: r = {1'b1, 4'hD};
            8'h1C: r = {1'b1, 4'h7};
            8'h1B: r = {1'b1, 4'h8};
            8'h23: r = {1'b1, 4'h9};
            8'h2B: r = {1'b1, 4'hE};
            8'h1A: r = {1'b1, 4'hA};
            8'h22: r = {1'b1, 4'h0};
            8'h21: r = {1'b1, 4'hB};
            8'h2A: r = {1'b1, 4'hF};
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // A level is accepted only after FILTER_LEN identical synced samples.
    always_comb begin
        flt_clk_d = flt_clk_q;
        flt_dat_d = flt_dat_q;
        if (&clk_hist_q) begin
            flt_clk_d = 1'b1;
        end else if (~|clk_hist_q) begin
            flt_clk_d = 1'b0;
        end
        if (&dat_hist_q) begin
            flt_dat_d = 1'b1;
        end else if (~|dat_hist_q) begin
            flt_dat_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_hist_q <= '1;
            dat_hist_q <= '1;
            flt_clk_q  <= 1'b1;
            flt_dat_q  <= 1'b1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_dat};
            clk_hist_q <= {clk_hist_q[FILTER_LEN-2:0], clk_sync_q[1]};
            dat_hist_q <= {dat_hist_q[FILTER_LEN-2:0], dat_sync_q[1]};
            flt_clk_q  <= flt_clk_d;
            flt_dat_q  <= flt_dat_d;
            clk_prev_q <= flt_clk_q;
        end
    end

    assign fall = clk_prev_q & ~flt_clk_q;
    assign smp  = flt_dat_q;

    always_comb begin
        rx_state_d   = rx_state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        tmo_d        = tmo_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        if (rx_state_q == RX_IDLE || fall) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end
        if (fall) begin
            unique case (rx_state_q)
                RX_IDLE: begin
                    if (!smp) begin
                        rx_state_d = RX_DATA;
                        bit_cnt_d  = 3'd0;
                    end
                end
                RX_DATA: begin
                    shift_d   = {smp, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_state_d = RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    if (^{shift_q, smp}) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_state_d  = RX_IDLE;
                        frame_err_d = 1'b1;
                    end
                end
                RX_STOP: begin
                    rx_state_d = RX_IDLE;
                    if (smp) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            endcase
        end else if (rx_state_q != RX_IDLE &&
                     tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            rx_state_d  = RX_IDLE;
            shift_d     = 8'h00;
            tmo_d       = '0;
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q   <= RX_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            tmo_q        <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            tmo_q        <= tmo_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // shift_q still holds the received byte while byte_valid_q is high.
    assign lut = map_code(shift_q);
    assign hit = lut[4];
    assign hex = lut[3:0];

    always_comb begin
        dec_d      = dec_q;
        keys_d     = keys_q;
        key_down_d = 1'b0;
        key_code_d = key_code_q;
        if (byte_valid_q) begin
            unique case (dec_q)
                D_IDLE: begin
                    if (shift_q == 8'hF0) begin
                        dec_d = D_BREAK;
                    end else if (shift_q == 8'hE0) begin
                        dec_d = D_EXT;
                    end else if (hit && !keys_q[hex]) begin
                        keys_d[hex] = 1'b1;
                        key_down_d  = 1'b1;
                        key_code_d  = hex;
                    end
                end
                D_BREAK: begin
                    dec_d = D_IDLE;
                    if (hit) begin
                        keys_d[hex] = 1'b0;
                    end
                end
                D_EXT: begin
                    dec_d = (shift_q == 8'hF0) ? D_EXT_BREAK : D_IDLE;
                end
                D_EXT_BREAK: begin
                    dec_d = D_IDLE;
                end
            endcase
        end
        if (kp.keys_clear) begin
            dec_d      = D_IDLE;
            keys_d     = 16'h0000;
            key_down_d = 1'b0;
            key_code_d = key_code_q;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dec_q      <= D_IDLE;
            keys_q     <= 16'h0000;
            key_down_q <= 1'b0;
            key_code_q <= 4'h0;
        end else begin
            dec_q      <= dec_d;
            keys_q     <= keys_d;
            key_down_q <= key_down_d;
            key_code_q <= key_code_d;
        end
    end

    assign kp.keys      = keys_q;
    assign kp.key_down  = key_down_q;
    assign kp.key_code  = key_code_q;
    assign kp.frame_err = frame_err_q;

endmodule
